// File: rtl/oped_axis_pkg.sv
// oped_axis_pkg: shared widths and FSM state for the OPED AXI4-Stream message path
package oped_axis_pkg;
    localparam int DAT_W = 256;
    localparam int STRB_W = 32;
    localparam int LEN_W = 16;
    localparam int SPT_W = 8;
    localparam int DPT_W = 8;
    localparam int ERR_W = 8;
    localparam int BYTES_PER_BEAT = 32;
    localparam int BEAT_W = 12;
    localparam int LANES = DAT_W / 32;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_GAP} state_t;
endpackage

// File: rtl/axis_strb_gen.sv
// axis_strb_gen: message length to beat count and last-beat byte strobe
module axis_strb_gen
    import oped_axis_pkg::*;
(
    input  logic [LEN_W-1:0]  msg_len,
    output logic [BEAT_W-1:0] beats,
    output logic [STRB_W-1:0] last_strb
);
    localparam int SH = $clog2(BYTES_PER_BEAT);
    logic [LEN_W:0] padded;
    logic [SH-1:0] rem;
    always_comb begin
        padded = {1'b0, msg_len} + (LEN_W+1)'(BYTES_PER_BEAT - 1);
        rem = msg_len[SH-1:0];
        beats = (msg_len == '0) ? BEAT_W'(1) : padded[LEN_W:SH];
        // an empty message still costs one beat, carried with no bytes enabled
        last_strb = (msg_len == '0) ? '0 : (rem == '0) ? '1 : (STRB_W'(1) << rem) - STRB_W'(1);
    end
endmodule

// File: rtl/axis_msg_source.sv
// axis_msg_source: programmable OPED message generator driving DAT/LEN/SPT/DPT/ERR streams
module axis_msg_source
    import oped_axis_pkg::*;
#(
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] SEED       = 32'h0000_0000
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic [15:0]       msg_count,
    input  logic [SPT_W-1:0]  spt,
    input  logic [DPT_W-1:0]  dpt,
    output logic              busy,
    output logic              done,
    output logic [15:0]       msgs_sent,
    output logic [DAT_W-1:0]  M_AXIS_DAT_TDATA,
    output logic              M_AXIS_DAT_TVALID,
    output logic [STRB_W-1:0] M_AXIS_DAT_TSTRB,
    output logic              M_AXIS_DAT_TLAST,
    input  logic              M_AXIS_DAT_TREADY,
    output logic [LEN_W-1:0]  M_AXIS_LEN_TDATA,
    output logic              M_AXIS_LEN_TVALID,
    input  logic              M_AXIS_LEN_TREADY,
    output logic [SPT_W-1:0]  M_AXIS_SPT_TDATA,
    output logic              M_AXIS_SPT_TVALID,
    input  logic              M_AXIS_SPT_TREADY,
    output logic [DPT_W-1:0]  M_AXIS_DPT_TDATA,
    output logic              M_AXIS_DPT_TVALID,
    input  logic              M_AXIS_DPT_TREADY,
    output logic [ERR_W-1:0]  M_AXIS_ERR_TDATA,
    output logic              M_AXIS_ERR_TVALID,
    input  logic              M_AXIS_ERR_TREADY
);
    state_t state, state_n;
    logic [LEN_W-1:0] len_q;
    logic [15:0] cnt_q;
    logic [SPT_W-1:0] spt_q;
    logic [DPT_W-1:0] dpt_q;
    logic [31:0] word;
    logic [BEAT_W-1:0] beat_idx, beats;
    logic [STRB_W-1:0] last_strb;
    logic [7:0] gap_cnt;
    logic [3:0] hdr_v, hdr_rdy;
    logic dat_v, dat_hs, last_beat, hdr_end, gap_end;

    axis_strb_gen u_strb (.msg_len(len_q), .beats(beats), .last_strb(last_strb));

    always_comb begin
        hdr_rdy = {M_AXIS_ERR_TREADY, M_AXIS_DPT_TREADY, M_AXIS_SPT_TREADY, M_AXIS_LEN_TREADY};
        dat_hs = dat_v & M_AXIS_DAT_TREADY;
        last_beat = beat_idx == beats - BEAT_W'(1);
        hdr_end = (hdr_v & ~hdr_rdy) == '0;
        gap_end = int'(gap_cnt) + 1 >= GAP_CYCLES;
        state_n = state == S_IDLE ? ((start && !busy && msg_count != '0) ? S_HDR : S_IDLE)
                : state == S_HDR  ? (hdr_end ? S_DATA : S_HDR)
                : state == S_DATA ? ((dat_hs && last_beat) ? ((msgs_sent + 16'd1 == cnt_q) ? S_IDLE : S_GAP) : S_DATA)
                : (gap_end ? S_HDR : S_GAP);
        M_AXIS_LEN_TVALID = hdr_v[0];
        M_AXIS_SPT_TVALID = hdr_v[1];
        M_AXIS_DPT_TVALID = hdr_v[2];
        M_AXIS_ERR_TVALID = hdr_v[3];
        M_AXIS_LEN_TDATA = hdr_v[0] ? len_q : '0;
        M_AXIS_SPT_TDATA = hdr_v[1] ? spt_q : '0;
        M_AXIS_DPT_TDATA = hdr_v[2] ? dpt_q : '0;
        M_AXIS_ERR_TDATA = '0;
        M_AXIS_DAT_TVALID = dat_v;
        M_AXIS_DAT_TLAST = dat_v & last_beat;
        M_AXIS_DAT_TSTRB = !dat_v ? '0 : last_beat ? last_strb : '1;
        M_AXIS_DAT_TDATA = '0;
        for (int i = 0; i < LANES; i++) M_AXIS_DAT_TDATA[32*i +: 32] = dat_v ? word + 32'(i) : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= S_IDLE;
            len_q <= '0;
            cnt_q <= '0;
            spt_q <= '0;
            dpt_q <= '0;
            word <= SEED;
            beat_idx <= '0;
            gap_cnt <= '0;
            hdr_v <= '0;
            dat_v <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            msgs_sent <= '0;
        end else begin
            state <= state_n;
            done <= 1'b0;
            hdr_v <= hdr_v & ~hdr_rdy;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : '0;
            // busy while idle only happens for a zero-count run awaiting its done pulse
            if (state == S_IDLE && busy) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (state == S_IDLE && !busy && start) begin
                len_q <= msg_len;
                cnt_q <= msg_count;
                spt_q <= spt;
                dpt_q <= dpt;
                word <= SEED;
                msgs_sent <= '0;
                busy <= 1'b1;
            end
            if (state_n == S_HDR && state != S_HDR) hdr_v <= '1;
            if (state == S_HDR && hdr_end) begin
                dat_v <= 1'b1;
                beat_idx <= '0;
            end
            if (dat_hs) begin
                word <= word + 32'd8;
                beat_idx <= beat_idx + BEAT_W'(1);
                if (last_beat) begin
                    dat_v <= 1'b0;
                    msgs_sent <= msgs_sent + 16'd1;
                    if (state_n == S_IDLE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
